// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream over valid/ready, assembles
// little-endian 32-bit words and writes them one per strobe into instruction
// memory, holding the CPU stalled while the load is in progress.
//
// Stream: N[7:0], N[15:8], then 4*N payload bytes (LSB first per word),
// then one checksum byte (XOR of payload) when IMEM_LOADER_CHECKSUM_EN is
// defined. Without that macro the checksum state and register do not exist.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid/byte_data  stream input
//   byte_ready            byte accepted this cycle (decoded from state only)
//   mem_we                one-cycle word write strobe
//   mem_addr/mem_wdata    byte address (BASE_ADDR + 4*word_idx) and word
//   cpu_hold              CPU stall while loading
//   done/error            level status of the last load
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CKSUM = 3'd5;
    // After the payload (or an empty header) the checksum byte is expected.
    localparam logic [2:0] S_END   = S_CKSUM;
`else
    localparam logic [2:0] S_END   = S_DONE;
`endif

    // Largest legal word count; 17 bits so 2^16 is representable.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    logic [2:0]  state;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  cksum;
`endif

    logic [15:0] hdr_n;
    assign hdr_n = {byte_data, n_words[7:0]};

    // All outputs are decoded from registered state; byte_ready in particular
    // never depends on byte_valid.
    assign byte_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || (state == S_CKSUM)
`endif
                        ;
    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = BASE_ADDR + {14'd0, word_idx, 2'b00};
    assign mem_wdata = word_buf;
    assign cpu_hold  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            cksum    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR0;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cksum    <= '0;
`endif
                    end
                end
                S_HDR0: begin
                    if (byte_valid) begin
                        n_words[7:0] <= byte_data;
                        state        <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (byte_valid) begin
                        n_words[15:8] <= byte_data;
                        if ({1'b0, hdr_n} > MAX_WORDS) state <= S_ERR;
                        else if (hdr_n == 16'd0)       state <= S_END;
                        else                           state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_valid) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        cksum    <= cksum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // mem_we is high for this single cycle; advance afterwards.
                    word_idx <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == n_words) state <= S_END;
                    else                             state <= S_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (byte_valid) state <= (byte_data == cksum) ? S_DONE : S_ERR;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
